pingpong_transpose: RTL
=======================

PINGPONG_TRANSPOSE -- requirements
Module: pingpong_transpose

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  - DW, 12, signed coefficient width per lane.
  - N, 8, block dimension (lanes per beat, beats per block); legal values 4 or 8.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  - i_clk, in, 1, single clock; all state on rising edge.
  - i_rst, in, 1, asynchronous active-high reset.
  - i_valid, in, 1, input row beat present.
  - o_ready, out, 1, module can accept an input row.
  - i_mode, in, 1, 0 = transpose, 1 = pass-through (row order).
  - i_data, in, N*DW, input row; lane c at bits [c*DW +: DW].
  - o_valid, out, 1, output beat present.
  - i_ready, in, 1, downstream accepts the output beat.
  - o_data, out, N*DW, output beat; lane k at bits [k*DW +: DW].
  - o_last, out, 1, final beat (index N-1) of a block.

Function
REQ-003 Storage SHALL be two banks (0/1), each N x N words of DW bits, plus per-bank flags full[b] and mode[b].
REQ-004 Write side SHALL hold wr_bank and wr_row (0..N-1); o_ready = !full[wr_bank], combinational from registers only.
REQ-005 An input beat SHALL be accepted when i_valid && o_ready; it stores lane c into bank[wr_bank][wr_row][c] and increments wr_row.
REQ-006 mode[wr_bank] SHALL be captured from i_mode on the accepted beat with wr_row==0; i_mode SHALL be ignored on all other beats.
REQ-007 On the accepted beat with wr_row==N-1, the block SHALL:
  - set full[wr_bank];
  - wrap wr_row to 0;
  - toggle wr_bank.
REQ-008 Read side SHALL hold rd_bank and rd_col (0..N-1); o_valid = full[rd_bank].
REQ-009 When mode[rd_bank]==0, lane k of o_data SHALL equal bank[rd_bank][k][rd_col]; when mode[rd_bank]==1, it SHALL equal bank[rd_bank][rd_col][k].
REQ-010 o_last SHALL equal o_valid && (rd_col==N-1).
REQ-011 An output beat SHALL fire when o_valid && i_ready; it increments rd_col.
REQ-012 On a firing beat with rd_col==N-1, the block SHALL:
  - clear full[rd_bank];
  - wrap rd_col to 0;
  - toggle rd_bank.
REQ-013 o_data and o_last SHALL remain stable while o_valid && !i_ready.
REQ-014 Latency: o_valid SHALL assert on the first clock edge after the N-th row of a block is accepted.
REQ-015 Throughput: with i_ready held high and i_valid held high, o_ready SHALL never deassert, and the block SHALL sustain one beat in and one beat out per cycle.
REQ-016 A set of full[wr_bank] and a clear of full[rd_bank] on the same edge SHALL both take effect.
REQ-017 A same-bank set and clear on the same edge is impossible by construction; verification SHALL assert it never occurs.
REQ-018 When both banks are full, o_ready SHALL be 0 and no write SHALL occur until a bank drains.
REQ-019 o_ready SHALL reassert on the edge that clears the drained bank's flag.
REQ-020 Data SHALL pass bit-exact; no rounding, saturation or sign change is applied.

Reset
REQ-021 While i_rst is high, the block SHALL hold:
  - wr_bank=0, wr_row=0, rd_bank=0, rd_col=0;
  - full[1:0]=0, mode[1:0]=0;
  - all storage words=0.
REQ-022 During and after reset, outputs SHALL be o_valid=0, o_ready=1, o_last=0, o_data=0.
REQ-023 Reset asserted mid-block SHALL discard all partial and full blocks; the next accepted beat SHALL be row 0 of bank 0.

Verification (N=8, DW=12)
REQ-024 Transpose: 8 rows with lane c of row r = 8r+c, mode 0, i_ready=1 -> the sequence SHALL be:
  - o_valid rises 1 cycle after row 7 is accepted;
  - beat j lane k = 8k+j;
  - o_last high only on beat 7.
REQ-025 Streaming: 3 back-to-back blocks, i_valid=1, i_ready=1 -> the block SHALL produce:
  - o_ready constantly 1;
  - 24 contiguous output beats;
  - block order preserved.
REQ-026 Backpressure: i_ready=0 while 17 rows are offered -> the block SHALL:
  - drop o_ready after the 16th acceptance;
  - stall row 17 until 8 output beats drain bank 0;
  - hold o_data stable throughout the stall.
REQ-027 Mode: a block with i_mode=1 at row 0 and i_mode toggled on rows 1-7 -> output beats SHALL equal the input rows in order.
REQ-028 Reset mid-block: assert i_rst after 5 rows -> the block SHALL:
  - return o_valid=0 and o_ready=1;
  - treat the next 8 rows as a fresh block that transposes correctly.
REQ-029 Extremes: lanes of -2048 and 2047 SHALL be reproduced unchanged at their transposed positions.

Source files
------------

// File: rtl/pingpong_transpose.sv
// -----------------------------------------------------------------------------
// pingpong_transpose
//
// Double-buffered N x N block transposer. Rows arrive one per beat and fill one
// bank. Meanwhile the other bank is read out one column per beat, or one row per
// beat when the block was written in pass-through mode. The two banks swap
// roles when a block is complete, so writing and reading can overlap fully.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. A source holds its data stable while valid && !ready.
// o_ready and o_valid are decoded from registers only and never depend on the
// i_valid or i_ready of the same cycle.
//
// Ports
//   i_clk    : clock, all state on the rising edge
//   i_rst    : asynchronous active-high reset
//   i_valid  : input row beat present
//   o_ready  : a row can be accepted (write bank not full)
//   i_mode   : 0 = transpose, 1 = pass-through; sampled on row 0 only
//   i_data   : input row, lane c at [c*DW +: DW]
//   o_valid  : output beat present (read bank full)
//   i_ready  : downstream accepts the output beat
//   o_data   : output beat, lane k at [k*DW +: DW]; zero while o_valid is low
//   o_last   : final beat (index N-1) of a block
// -----------------------------------------------------------------------------
module pingpong_transpose #(
  parameter int DW = 12,
  parameter int N  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mode,
  input  logic [N*DW-1:0] i_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [N*DW-1:0] o_data,
  output logic            o_last
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

  // Each bank is stored as N packed rows so a whole input row is one write.
  logic [N*DW-1:0] mem_q [2][N];

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [RW-1:0] rd_col_q, rd_col_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    mode_q, mode_d;

  logic accept;
  logic fire;
  logic wr_last;
  logic rd_last;
  logic set_full;
  logic clr_full;

  assign o_ready = !full_q[wr_bank_q];
  assign o_valid = full_q[rd_bank_q];

  assign accept   = i_valid && o_ready;
  assign fire     = o_valid && i_ready;
  assign wr_last  = (wr_row_q == LAST_IDX);
  assign rd_last  = (rd_col_q == LAST_IDX);
  assign set_full = accept && wr_last;
  assign clr_full = fire && rd_last;

  // ---------------------------------------------------------------------------
  // Next-state logic for the write and read pointers and the bank flags.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;
    mode_d    = mode_q;

    if (accept) begin
      if (wr_row_q == '0) begin
        mode_d[wr_bank_q] = i_mode;
      end
      if (wr_last) begin
        wr_row_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + RW'(1);
      end
    end

    if (fire) begin
      if (rd_last) begin
        rd_col_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_col_d = rd_col_q + RW'(1);
      end
    end

    // Clear first, then set: the two always address different banks, so
    // both updates land on the same edge.
    if (clr_full) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (set_full) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= '0;
      full_q    <= '0;
      mode_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. A row can only be written into a bank that is not full, so the
  // read side never sees its bank change underneath it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else if (accept) begin
      mem_q[wr_bank_q][wr_row_q] <= i_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux. Transpose: lane k is column rd_col of row k.
  // Pass-through: lane k is lane k of row rd_col.
  // ---------------------------------------------------------------------------
  logic [N*DW-1:0] rd_word;

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [DW-1:0] lane_t;
    logic [DW-1:0] lane_p;
    assign lane_t = mem_q[rd_bank_q][k][rd_col_q*DW +: DW];
    assign lane_p = mem_q[rd_bank_q][rd_col_q][k*DW +: DW];
    assign rd_word[k*DW +: DW] = mode_q[rd_bank_q] ? lane_p : lane_t;
  end

  assign o_data = o_valid ? rd_word : '0;
  assign o_last = o_valid && rd_last;

  // A bank cannot be both written-complete and drained on the same edge:
  // writing needs it empty, draining needs it full.
  a_no_same_bank_set_clr : assert property (
    @(posedge i_clk) disable iff (i_rst)
      !(set_full && clr_full && (wr_bank_q == rd_bank_q))
  );

endmodule
